// File: rtl/phase_clock_gen.sv
// Machine-cycle clock generator: divides fpga_clk into phi_0/phi_1/phi_2 with
// run-time low/high phase lengths, stretch, halt, strobes and a cycle counter.
module phase_clock_gen #(
    parameter int DIV_W   = 8,
    parameter int GAP     = 1,
    parameter int SKEW    = 1,
    parameter int STRETCH = 2,
    parameter int CNT_W   = 16
) (
    input  logic             fpga_clk,
    input  logic             reset,
    input  logic [DIV_W-1:0] div_lo,
    input  logic [DIV_W-1:0] div_hi,
    input  logic             stretch,
    input  logic             halt,
    output logic             phi_0,
    output logic             phi_1,
    output logic             phi_2,
    output logic             clk,
    output logic             phi2_fall,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int EW = DIV_W + 1;
    localparam logic [0:0]    ST_LOW    = 1'b0;
    localparam logic [0:0]    ST_HIGH   = 1'b1;
    localparam logic [EW-1:0] LO_MIN    = EW'(2 * GAP + 1);
    localparam logic [EW-1:0] STRETCH_W = EW'(STRETCH);
    localparam logic [EW-1:0] GAP_W     = EW'(GAP);
    localparam logic [EW-1:0] ONE       = EW'(1);

    logic [0:0]       state_q, state_d;
    logic [EW-1:0]    cnt_q, cnt_d;
    logic [DIV_W-1:0] lo_lat_q, lo_lat_d;
    logic [DIV_W-1:0] hi_lat_q, hi_lat_d;
    logic             stretch_lat_q, stretch_lat_d;
    logic             phi_0_q, phi_0_d;
    logic             phi_1_q, phi_1_d;
    logic             clk_q, clk_d;
    logic             phi2_fall_q, phi2_fall_d;
    logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
    logic [EW-1:0]    lo_eff, hi_eff, lo_eff_d, hi_eff_d;

    function automatic logic [EW-1:0] lo_eff_f(input logic [DIV_W-1:0] lo, input logic st);
        logic [EW-1:0] sum;
        sum = {1'b0, lo} + (st ? STRETCH_W : '0);
        return (sum < LO_MIN) ? LO_MIN : sum;
    endfunction

    function automatic logic [EW-1:0] hi_eff_f(input logic [DIV_W-1:0] hi);
        return (hi == '0) ? ONE : {1'b0, hi};
    endfunction

    always_comb begin
        lo_eff        = lo_eff_f(lo_lat_q, stretch_lat_q);
        hi_eff        = hi_eff_f(hi_lat_q);
        state_d       = state_q;
        cnt_d         = cnt_q;
        lo_lat_d      = lo_lat_q;
        hi_lat_d      = hi_lat_q;
        stretch_lat_d = stretch_lat_q;
        if (state_q == ST_LOW) begin
            if (cnt_q >= lo_eff - ONE) begin
                if (!halt) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = lo_eff - ONE;
                end
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end else begin
            // Divider settings are only sampled here, so a phase never changes length midway.
            if (cnt_q >= hi_eff - ONE) begin
                state_d       = ST_LOW;
                cnt_d         = '0;
                lo_lat_d      = div_lo;
                hi_lat_d      = div_hi;
                stretch_lat_d = stretch;
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end

        // Outputs are registered from the next state so they line up with state_q.
        lo_eff_d      = lo_eff_f(lo_lat_d, stretch_lat_d);
        hi_eff_d      = hi_eff_f(hi_lat_d);
        phi_0_d       = (state_d == ST_HIGH);
        phi_1_d       = (state_d == ST_LOW) && (cnt_d >= GAP_W) && (cnt_d < lo_eff_d - GAP_W);
        clk_d         = (state_d == ST_HIGH) && (cnt_d == '0);
        phi2_fall_d   = (state_d == ST_HIGH) && (cnt_d == hi_eff_d - ONE);
        cycle_count_d = cycle_count_q + CNT_W'(clk_q);
    end

    always_ff @(posedge fpga_clk) begin
        if (reset) begin
            state_q       <= ST_LOW;
            cnt_q         <= '0;
            lo_lat_q      <= div_lo;
            hi_lat_q      <= div_hi;
            stretch_lat_q <= 1'b0;
            phi_0_q       <= 1'b0;
            phi_1_q       <= 1'b0;
            clk_q         <= 1'b0;
            phi2_fall_q   <= 1'b0;
            cycle_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            lo_lat_q      <= lo_lat_d;
            hi_lat_q      <= hi_lat_d;
            stretch_lat_q <= stretch_lat_d;
            phi_0_q       <= phi_0_d;
            phi_1_q       <= phi_1_d;
            clk_q         <= clk_d;
            phi2_fall_q   <= phi2_fall_d;
            cycle_count_q <= cycle_count_d;
        end
    end

    generate
        if (SKEW == 0) begin : g_no_skew
            assign phi_2 = phi_0_q;
        end else begin : g_skew
            logic [SKEW-1:0] skew_q, skew_d;
            genvar gi;
            for (gi = 0; gi < SKEW; gi++) begin : g_tap
                if (gi == 0) begin : g_first
                    assign skew_d[gi] = phi_0_q;
                end else begin : g_next
                    assign skew_d[gi] = skew_q[gi-1];
                end
            end
            always_ff @(posedge fpga_clk) begin
                if (reset) begin
                    skew_q <= '0;
                end else begin
                    skew_q <= skew_d;
                end
            end
            assign phi_2 = skew_q[SKEW-1];
        end
    endgenerate

    assign phi_0       = phi_0_q;
    assign phi_1       = phi_1_q;
    assign clk         = clk_q;
    assign phi2_fall   = phi2_fall_q;
    assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_phase_clock_gen.sv
// Bench for phase_clock_gen: directed scenarios then random stimulus, every
// cycle compared against a position-in-period reference model.
module tb_phase_clock_gen;

    localparam int DIV_W   = 8;
    localparam int GAP     = 1;
    localparam int SKEW    = 1;
    localparam int STRETCH = 2;
    localparam int CNT_W   = 16;

    logic             fpga_clk = 1'b0;
    logic             reset;
    logic [DIV_W-1:0] div_lo, div_hi;
    logic             stretch, halt;
    logic             phi_0, phi_1, phi_2, clk, phi2_fall;
    logic [CNT_W-1:0] cycle_count;

    phase_clock_gen #(
        .DIV_W(DIV_W), .GAP(GAP), .SKEW(SKEW), .STRETCH(STRETCH), .CNT_W(CNT_W)
    ) dut (
        .fpga_clk   (fpga_clk),
        .reset      (reset),
        .div_lo     (div_lo),
        .div_hi     (div_hi),
        .stretch    (stretch),
        .halt       (halt),
        .phi_0      (phi_0),
        .phi_1      (phi_1),
        .phi_2      (phi_2),
        .clk        (clk),
        .phi2_fall  (phi2_fall),
        .cycle_count(cycle_count)
    );

    always #5 fpga_clk = ~fpga_clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: position within the machine cycle, 0..lo+hi-1, with the lengths
    // fixed at the start of each cycle.
    int m_pos   = 0;
    int m_lo    = 3;
    int m_hi    = 1;
    int m_count = 0;
    bit m_zero  = 1'b1;
    bit m_hist [0:7];

    function automatic int eff_lo(input int lo, input bit st);
        int v;
        v = lo + (st ? STRETCH : 0);
        return (v < 2 * GAP + 1) ? 2 * GAP + 1 : v;
    endfunction

    function automatic int eff_hi(input int hi);
        return (hi < 1) ? 1 : hi;
    endfunction

    function automatic bit e_phi0();
        return !m_zero && (m_pos >= m_lo);
    endfunction

    function automatic bit e_phi1();
        return !m_zero && (m_pos >= GAP) && (m_pos < m_lo - GAP);
    endfunction

    function automatic bit e_clk();
        return !m_zero && (m_pos == m_lo);
    endfunction

    function automatic bit e_fall();
        return !m_zero && (m_pos == m_lo + m_hi - 1);
    endfunction

    function automatic bit e_phi2();
        return (SKEW == 0) ? e_phi0() : m_hist[SKEW-1];
    endfunction

    task automatic model_edge();
        bit old_phi0, old_clk;
        old_phi0 = e_phi0();
        old_clk  = e_clk();
        if (reset) begin
            m_pos   = 0;
            m_lo    = eff_lo(int'(div_lo), 1'b0);
            m_hi    = eff_hi(int'(div_hi));
            m_zero  = 1'b1;
            m_count = 0;
            for (int i = 0; i < 8; i++) m_hist[i] = 1'b0;
        end else begin
            m_zero  = 1'b0;
            m_count = (m_count + int'(old_clk)) % (1 << CNT_W);
            for (int i = 7; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = old_phi0;
            if (!(m_pos == m_lo - 1 && halt)) m_pos++;
            if (m_pos == m_lo + m_hi) begin
                m_pos = 0;
                m_lo  = eff_lo(int'(div_lo), stretch);
                m_hi  = eff_hi(int'(div_hi));
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge fpga_clk);
        model_edge();
        cyc++;
        #1;
        chk("phi_0", 32'(phi_0), 32'(e_phi0()));
        chk("phi_1", 32'(phi_1), 32'(e_phi1()));
        chk("phi_2", 32'(phi_2), 32'(e_phi2()));
        chk("clk", 32'(clk), 32'(e_clk()));
        chk("phi2_fall", 32'(phi2_fall), 32'(e_fall()));
        chk("cycle_count", 32'(cycle_count), 32'(m_count));
    endtask

    initial begin
        for (int i = 0; i < 8; i++) m_hist[i] = 1'b0;
        reset   = 1'b1;
        div_lo  = 8'd4;
        div_hi  = 8'd4;
        stretch = 1'b0;
        halt    = 1'b0;
        repeat (3) step();
        chk("reset_phi_0", 32'(phi_0), 32'd0);
        chk("reset_count", 32'(cycle_count), 32'd0);

        $display("phase basic 4L/4H");
        reset = 1'b0;
        cyc   = 0;
        while (cyc < 3) step();
        chk("first_low_end", 32'(phi_0), 32'd0);
        step();
        chk("first_rise", 32'(phi_0), 32'd1);
        chk("first_clk", 32'(clk), 32'd1);
        while (cyc < 77) step();
        chk("count_after_10_rises", 32'(cycle_count), 32'd10);

        $display("phase stretch");
        stretch = 1'b1;
        while (cyc < 80) step();
        stretch = 1'b0;
        while (cyc < 85) step();
        chk("stretch_low6_end", 32'(phi_0), 32'd0);
        step();
        chk("stretch_rise", 32'(phi_0), 32'd1);
        while (cyc < 93) step();
        chk("normal_low4_end", 32'(phi_0), 32'd0);
        step();
        chk("normal_rise", 32'(phi_0), 32'd1);

        $display("phase halt");
        while (cyc < 101) step();
        halt = 1'b1;
        repeat (10) step();
        halt = 1'b0;
        chk("halt_phi_0", 32'(phi_0), 32'd0);
        chk("halt_phi_1", 32'(phi_1), 32'd0);
        step();
        chk("halt_release_rise", 32'(phi_0), 32'd1);

        $display("phase clamp div_lo=2 div_hi=0");
        div_lo = 8'd2;
        div_hi = 8'd0;
        while (cyc < 117) step();
        chk("clamp_phi1_on", 32'(phi_1), 32'd1);
        step();
        chk("clamp_phi1_off", 32'(phi_1), 32'd0);
        step();
        chk("hi1_clk", 32'(clk), 32'd1);
        chk("hi1_fall", 32'(phi2_fall), 32'd1);
        while (cyc < 130) step();

        $display("phase mid-HIGH change and reset");
        div_lo = 8'd4;
        div_hi = 8'd4;
        while (cyc < 137) step();
        div_hi = 8'd7;
        while (cyc < 139) step();
        chk("old_hi_kept_fall", 32'(phi2_fall), 32'd1);
        step();
        chk("old_hi_kept_low", 32'(phi_0), 32'd0);
        while (cyc < 146) step();
        reset = 1'b1;
        step();
        chk("midreset_phi_0", 32'(phi_0), 32'd0);
        chk("midreset_clk", 32'(clk), 32'd0);
        chk("midreset_count", 32'(cycle_count), 32'd0);
        step();
        reset = 1'b0;
        repeat (30) step();

        $display("phase random");
        repeat (600) begin
            reset   = ($urandom_range(0, 99) == 0);
            div_lo  = 8'($urandom_range(0, 9));
            div_hi  = 8'($urandom_range(0, 6));
            stretch = ($urandom_range(0, 3) == 0);
            halt    = ($urandom_range(0, 5) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
